ripple_adder: RTL and testbench
===============================

RIPPLE_ADDER -- requirements
Module: ripple_adder

Interface
REQ-001 Parameter WIDTH, default 4: operand and sum width in bits; legal range 1..32.
REQ-002 Port clk, input, 1 bit: sole clock; all registered outputs update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port X, input, WIDTH bits: operand A, unsigned.
REQ-005 Port Y, input, WIDTH bits: operand B, unsigned.
REQ-006 Port Z, input, 1 bit: carry-in.
REQ-007 Port S, output, WIDTH bits: combinational sum, bits WIDTH-1..0 of X+Y+Z.
REQ-008 Port Co, output, 1 bit: combinational carry-out, bit WIDTH of X+Y+Z.
REQ-009 Port S_r, output, WIDTH bits: registered copy of S.
REQ-010 Port Co_r, output, 1 bit: registered copy of Co.
REQ-011 Port Ovf_r, output, 1 bit: registered two's-complement overflow flag.

Function
REQ-012 The adder SHALL be a chain of WIDTH full-adder cells.
  - Cell 0 carry-in is Z.
  - Cell i carry-out feeds cell i+1.
  - Cell WIDTH-1 carry-out drives Co.
REQ-013 Each full-adder cell SHALL compute:
  - s = a XOR b XOR cin
  - cout = (a AND b) OR (cin AND (a XOR b))
REQ-014 {Co,S} SHALL equal X+Y+Z, computed at WIDTH+1 bits, for every input combination. Result range is 0..(2^(WIDTH+1)-1).
REQ-015 S and Co SHALL be purely combinational.
  - Zero clock latency.
  - Independent of clk and rst.
  - Settled within one input-change interval; no latches.
REQ-016 Overflow SHALL be defined as the XOR of the carry into the MSB cell and the carry out of the MSB cell. It is equivalent to operands of equal sign producing a sum of opposite sign.
REQ-017 On each rising clk edge with rst low, the block SHALL load S_r<=S, Co_r<=Co, Ovf_r<=overflow.
  - Registered outputs have 1-cycle latency.
  - There is no enable; every edge loads.
REQ-018 Carry propagation SHALL wrap correctly: an all-ones operand plus carry-in produces S=0 and Co=1 when the other operand is zero.
REQ-019 Unknown (X/Z) inputs are out of scope. Outputs for them are unspecified but SHALL NOT affect later cycles once inputs are known.

Reset
REQ-020 While rst is high, S_r, Co_r and Ovf_r SHALL be 0, asserted immediately without waiting for a clk edge.
REQ-021 S and Co SHALL be unaffected by rst at all times.
REQ-022 After rst deasserts, the first rising clk edge SHALL load the current combinational result.
REQ-023 Asserting rst mid-operation SHALL discard the registered result.

Verification
REQ-024 Exhaustive sweep for WIDTH=4: all 512 {X,Y,Z} combinations, one every 10 time units -> {Co,S}==X+Y+Z for every case, with PASS/FAIL reported per case.
REQ-025 Corner cases:
  - X=0, Y=0, Z=0 -> S=0, Co=0.
  - X=15, Y=15, Z=1 -> S=15, Co=1.
  - X=15, Y=0, Z=1 -> S=0, Co=1 (full ripple).
REQ-026 Signed overflow:
  - X=7, Y=1, Z=0 -> S=8, Co=0; after one clk, Ovf_r=1.
  - X=8, Y=8, Z=0 -> S=0, Co=1; after one clk, Ovf_r=1.
REQ-027 Registered path: with X=9, Y=4, Z=1, then a clk edge -> S_r=14, Co_r=0, Ovf_r=0. Before the edge, the registered outputs hold their previous values.
REQ-028 Reset mid-operation: with registered outputs nonzero, raise rst between clk edges -> S_r, Co_r, Ovf_r go to 0 immediately while S/Co keep tracking inputs. Release rst -> the next edge reloads.

Source files
------------

// File: rtl/ripple_adder.sv
// ----------------------------------------------------------------------------
// ripple_adder
//   Unsigned WIDTH-bit ripple-carry adder built from a chain of full-adder
//   cells. It has a combinational sum/carry path and a registered copy of the
//   result that also carries a two's-complement overflow flag.
//
// Parameters
//   WIDTH  : operand and sum width in bits (1..32)
//
// Ports
//   clk    in   rising-edge clock for the registered outputs
//   rst    in   asynchronous active-high reset; clears S_r/Co_r/Ovf_r only
//   X      in   operand A (unsigned)
//   Y      in   operand B (unsigned)
//   Z      in   carry-in
//   S      out  combinational sum, bits WIDTH-1..0 of X+Y+Z
//   Co     out  combinational carry-out, bit WIDTH of X+Y+Z
//   S_r    out  registered S
//   Co_r   out  registered Co
//   Ovf_r  out  registered signed overflow (carry into MSB ^ carry out of MSB)
// ----------------------------------------------------------------------------
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Z,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic [WIDTH-1:0] S_r,
    output logic             Co_r,
    output logic             Ovf_r
);

    // Full-adder cell equations.
    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_p0;
    logic             ovf_p0;

    // The chain is evaluated in one always_comb so each cell reads the
    // carry written by the previous iteration, giving a true ripple.
    always_comb begin
        carry    = '0;
        sum_p0   = '0;
        carry[0] = Z;
        for (int i = 0; i < WIDTH; i++) begin
            sum_p0[i]  = fa_sum(X[i], Y[i], carry[i]);
            carry[i+1] = fa_carry(X[i], Y[i], carry[i]);
        end
    end

    // Signed overflow: carries into and out of the MSB cell disagree.
    assign ovf_p0 = carry[WIDTH] ^ carry[WIDTH-1];

    assign S  = sum_p0;
    assign Co = carry[WIDTH];

    // ---- stage p0 -> registered outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_r   <= '0;
            Co_r  <= 1'b0;
            Ovf_r <= 1'b0;
        end else begin
            S_r   <= sum_p0;
            Co_r  <= carry[WIDTH];
            Ovf_r <= ovf_p0;
        end
    end

endmodule

// File: tb/tb_ripple_adder.sv
// ----------------------------------------------------------------------------
// tb_ripple_adder
//   Self-checking bench for ripple_adder at WIDTH=4: reset behaviour,
//   directed corner and overflow vectors, registered-path latency, reset in
//   mid-operation, and an exhaustive sweep of all {X,Y,Z} combinations.
// ----------------------------------------------------------------------------
module tb_ripple_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] X, Y;
    logic         Z;
    logic [W-1:0] S, S_r;
    logic         Co, Co_r, Ovf_r;

    int n_cmp = 0;
    int n_err = 0;

    ripple_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .X    (X),
        .Y    (Y),
        .Z    (Z),
        .S    (S),
        .Co   (Co),
        .S_r  (S_r),
        .Co_r (Co_r),
        .Ovf_r(Ovf_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        @(negedge clk);
        X = x;
        Y = y;
        Z = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sum, sa, sb, sv, ovf;

        // Reset held from time 0: registers cleared, comb path live.
        rst = 1'b1;
        X   = 4'd5;
        Y   = 4'd6;
        Z   = 1'b1;
        #1;
        chk("rst_S_r",   32'(S_r),   0);
        chk("rst_Co_r",  32'(Co_r),  0);
        chk("rst_Ovf_r", 32'(Ovf_r), 0);
        chk("rst_comb",  32'({Co, S}), 12);
        tick();
        chk("rst_hold_S_r", 32'(S_r), 0);

        // First edge after release loads the current result.
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_S_r",  32'(S_r),  12);
        chk("rel_Co_r", 32'(Co_r), 0);

        // Corner cases.
        drive(4'd0, 4'd0, 1'b0);
        chk("zero_comb", 32'({Co, S}), 0);
        drive(4'd15, 4'd15, 1'b1);
        chk("max_S",  32'(S),  15);
        chk("max_Co", 32'(Co), 1);
        drive(4'd15, 4'd0, 1'b1);
        chk("ripple_S",  32'(S),  0);
        chk("ripple_Co", 32'(Co), 1);
        tick();
        chk("ripple_S_r",  32'(S_r),  0);
        chk("ripple_Co_r", 32'(Co_r), 1);

        // Registered path: before the edge the old value (0 / carry 1) holds.
        drive(4'd9, 4'd4, 1'b1);
        chk("reg_comb",    32'({Co, S}), 14);
        chk("reg_pre_S_r", 32'(S_r),  0);
        chk("reg_pre_Co_r", 32'(Co_r), 1);
        tick();
        chk("reg_S_r",   32'(S_r),   14);
        chk("reg_Co_r",  32'(Co_r),  0);
        chk("reg_Ovf_r", 32'(Ovf_r), 0);

        // Reset mid-operation between edges.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_S_r",   32'(S_r),   0);
        chk("mid_Co_r",  32'(Co_r),  0);
        chk("mid_Ovf_r", 32'(Ovf_r), 0);
        X = 4'd3;
        Y = 4'd5;
        Z = 1'b0;
        #1;
        chk("mid_comb", 32'({Co, S}), 8);
        tick();
        chk("mid_hold_S_r", 32'(S_r), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_pre_S_r", 32'(S_r), 0);
        tick();
        chk("mid_rel_S_r",   32'(S_r),   8);
        chk("mid_rel_Ovf_r", 32'(Ovf_r), 1);

        // Signed overflow vectors.
        drive(4'd7, 4'd1, 1'b0);
        chk("ovf_pos_comb", 32'({Co, S}), 8);
        tick();
        chk("ovf_pos_Ovf_r", 32'(Ovf_r), 1);
        drive(4'd8, 4'd8, 1'b0);
        chk("ovf_neg_S",  32'(S),  0);
        chk("ovf_neg_Co", 32'(Co), 1);
        tick();
        chk("ovf_neg_Ovf_r", 32'(Ovf_r), 1);
        chk("ovf_neg_Co_r",  32'(Co_r),  1);

        // Exhaustive sweep: one vector per clock period.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(a[W-1:0], b[W-1:0], c[0]);
                    sum = a + b + c;
                    chk("sweep_comb", 32'({Co, S}), sum);
                    sa  = (a > 7) ? a - 16 : a;
                    sb  = (b > 7) ? b - 16 : b;
                    sv  = sa + sb + c;
                    ovf = (sv > 7 || sv < -8) ? 1 : 0;
                    tick();
                    chk("sweep_reg", 32'({Co_r, S_r}), sum);
                    chk("sweep_ovf", 32'(Ovf_r), ovf);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
